// File: rtl/alu_issue_stage.sv
// Decode/execute boundary: resolves operands, builds ALU control and holds it in a
// main + skid register pair. Define ALU_ISSUE_FWD_EN to enable EX/MEM and MEM/WB forwarding.
module alu_issue_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic [XLEN-1:0] in_pc,
    input  logic [RA_W-1:0] in_rs1_addr,
    input  logic [RA_W-1:0] in_rs2_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            fwd_ex_valid,
    input  logic [RA_W-1:0] fwd_ex_rd,
    input  logic [XLEN-1:0] fwd_ex_data,
    input  logic            fwd_wb_valid,
    input  logic [RA_W-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_cntl,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [XLEN-1:0] out_store_data,
    output logic            out_illegal
);

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_XOR   = 4'b0010;
    localparam logic [3:0] ALU_ADD   = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRA   = 4'b1000;
    localparam logic [3:0] ALU_SRL   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;
    localparam logic [3:0] ALU_ILL   = 4'b1111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef struct packed {
        logic [3:0]      cntl;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] sd;
        logic            illegal;
    } entry_t;

    // Operand resolution, index 0 = rs1, index 1 = rs2
    logic [1:0][RA_W-1:0] src_addr;
    logic [1:0][XLEN-1:0] src_rf;
    logic [1:0][XLEN-1:0] src_val;

    assign src_addr = {in_rs2_addr, in_rs1_addr};
    assign src_rf   = {in_rs2_data, in_rs1_data};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
`ifdef ALU_ISSUE_FWD_EN
            // x0 check first also guarantees forwarding never matches rd==0
            assign src_val[gi] = (src_addr[gi] == '0) ? '0 :
                                 (fwd_ex_valid && (fwd_ex_rd == src_addr[gi])) ? fwd_ex_data :
                                 (fwd_wb_valid && (fwd_wb_rd == src_addr[gi])) ? fwd_wb_data :
                                 src_rf[gi];
`else
            assign src_val[gi] = (src_addr[gi] == '0) ? '0 : src_rf[gi];
`endif
        end
    endgenerate

`ifndef ALU_ISSUE_FWD_EN
    logic fwd_unused;
    assign fwd_unused = ^{fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
                          fwd_wb_valid, fwd_wb_rd, fwd_wb_data};
`endif

    // Decode
    logic [3:0]      dec_cntl;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic            dec_ill;
    entry_t          new_entry;

    always_comb begin
        dec_cntl = ALU_ADD;
        dec_a    = src_val[0];
        dec_b    = src_val[1];
        dec_ill  = 1'b0;
        case (in_opcode)
            OPC_OP, OPC_OPIMM: begin
                if (in_opcode == OPC_OPIMM) begin
                    dec_b = in_imm;
                end
                case (in_funct3)
                    3'b000: dec_cntl = (in_opcode == OPC_OP && in_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001: begin
                        dec_cntl = ALU_SLL;
                        if (in_opcode == OPC_OPIMM && in_funct7b5) begin
                            dec_ill = 1'b1;
                        end
                    end
                    3'b010:  dec_cntl = ALU_SLT;
                    3'b011:  dec_cntl = ALU_SLTU;
                    3'b100:  dec_cntl = ALU_XOR;
                    3'b101:  dec_cntl = in_funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  dec_cntl = ALU_OR;
                    default: dec_cntl = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                dec_cntl = ALU_PASSB;
                dec_a    = '0;
                dec_b    = in_imm;
            end
            OPC_AUIPC: begin
                dec_a = in_pc;
                dec_b = in_imm;
            end
            OPC_LOAD, OPC_STORE: begin
                dec_b = in_imm;
            end
            OPC_BRANCH: begin
                case (in_funct3)
                    3'b000, 3'b001: dec_cntl = ALU_SUB;
                    3'b100, 3'b101: dec_cntl = ALU_SLT;
                    3'b110, 3'b111: dec_cntl = ALU_SLTU;
                    default:        dec_ill  = 1'b1;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                dec_a = in_pc;
                dec_b = XLEN'(4);
            end
            default: dec_ill = 1'b1;
        endcase
        // Every illegal entry presents the same inert operands to the ALU
        if (dec_ill) begin
            dec_cntl = ALU_ILL;
            dec_a    = '0;
            dec_b    = '0;
        end
    end

    assign new_entry = '{cntl: dec_cntl, a: dec_a, b: dec_b, sd: src_val[1], illegal: dec_ill};

    // Main (M) and skid (S) storage
    logic   m_valid_reg, m_valid_next;
    logic   s_valid_reg, s_valid_next;
    entry_t m_reg, m_next;
    entry_t s_reg, s_next;
    logic   accept;
    logic   consume;

    assign in_ready = !s_valid_reg;
    assign accept   = in_valid && in_ready;
    assign consume  = m_valid_reg && out_ready;

    always_comb begin
        m_valid_next = m_valid_reg;
        s_valid_next = s_valid_reg;
        m_next       = m_reg;
        s_next       = s_reg;
        if (flush) begin
            m_valid_next = 1'b0;
            s_valid_next = 1'b0;
        end else if (!m_valid_reg || consume) begin
            if (s_valid_reg) begin
                m_next       = s_reg;
                m_valid_next = 1'b1;
                s_valid_next = accept;
                if (accept) begin
                    s_next = new_entry;
                end
            end else begin
                m_valid_next = accept;
                if (accept) begin
                    m_next = new_entry;
                end
            end
        end else if (accept) begin
            s_next       = new_entry;
            s_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_reg <= 1'b0;
            s_valid_reg <= 1'b0;
            m_reg       <= '0;
            s_reg       <= '0;
        end else begin
            m_valid_reg <= m_valid_next;
            s_valid_reg <= s_valid_next;
            m_reg       <= m_next;
            s_reg       <= s_next;
        end
    end

    assign out_valid      = m_valid_reg;
    assign out_cntl       = m_reg.cntl;
    assign out_a          = m_reg.a;
    assign out_b          = m_reg.b;
    assign out_store_data = m_reg.sd;
    assign out_illegal    = m_reg.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: reset, decode vectors, skid back-pressure,
// forwarding, flush and asynchronous reset.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [31:0] in_pc;
    logic [4:0]  in_rs1_addr;
    logic [4:0]  in_rs2_addr;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] in_imm;
    logic        fwd_ex_valid;
    logic [4:0]  fwd_ex_rd;
    logic [31:0] fwd_ex_data;
    logic        fwd_wb_valid;
    logic [4:0]  fwd_wb_rd;
    logic [31:0] fwd_wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_cntl;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [31:0] out_store_data;
    logic        out_illegal;

    int passed = 0;
    int total  = 0;

    alu_issue_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_pc(in_pc), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_cntl(out_cntl),
        .out_a(out_a), .out_b(out_b), .out_store_data(out_store_data),
        .out_illegal(out_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
        in_valid    = 1'b1;
        in_opcode   = op;
        in_funct3   = f3;
        in_funct7b5 = b5;
        in_rs1_addr = r1;
        in_rs2_addr = r2;
        in_rs1_data = d1;
        in_rs2_data = d2;
        in_imm      = imm;
    endtask

    // One decode vector: rs1=x3=0x100, rs2=x4=0x200, pc=0x1000, imm=0xFFFFFFF0
    task automatic vec(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic b5,
                       input logic [3:0] ec, input logic chk_a, input logic [31:0] ea,
                       input logic [31:0] eb, input logic eill);
        offer(op, f3, b5, 5'd3, 5'd4, 32'h100, 32'h200, 32'hFFFF_FFF0);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_cntl"}, 32'(out_cntl), 32'(ec));
        if (chk_a) check({tag, "_a"}, out_a, ea);
        check({tag, "_b"}, out_b, eb);
        check({tag, "_sd"}, out_store_data, 32'h200);
        check({tag, "_ill"}, 32'(out_illegal), 32'(eill));
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = '0; in_funct3 = '0; in_funct7b5 = 1'b0; in_pc = 32'h1000;
        in_rs1_addr = '0; in_rs2_addr = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
        fwd_ex_valid = 1'b0; fwd_ex_rd = '0; fwd_ex_data = '0;
        fwd_wb_valid = 1'b0; fwd_wb_rd = '0; fwd_wb_data = '0;

        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_cntl", 32'(out_cntl), 32'd0);
        check("rst_a", out_a, 32'd0);
        check("rst_b", out_b, 32'd0);
        check("rst_sd", out_store_data, 32'd0);
        check("rst_ill", 32'(out_illegal), 32'd0);
        rst_n = 1'b1;
        check("rst_ready", 32'(in_ready), 32'd1);

        // ADD x3,x1,x2
        out_ready = 1'b1;
        offer(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0);
        tick();
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_cntl", 32'(out_cntl), 32'h3);
        check("add_a", out_a, 32'd5);
        check("add_b", out_b, 32'd7);

        // SRAI x1,x1,4
        offer(7'b0010011, 3'b101, 1'b1, 5'd1, 5'd0, 32'h8000_0000, 32'd0, 32'h404);
        tick();
        check("srai_cntl", 32'(out_cntl), 32'h8);
        check("srai_a", out_a, 32'h8000_0000);
        check("srai_b", out_b, 32'h404);
        check("srai_ill", 32'(out_illegal), 32'd0);
        in_valid = 1'b0;
        tick();
        check("srai_drained", 32'(out_valid), 32'd0);

        // Back-pressure: I1 ADDI, I2 XORI, I3 ORI
        out_ready = 1'b0;
        offer(7'b0010011, 3'b000, 1'b0, 5'd1, 5'd0, 32'd10, 32'd0, 32'd1);
        tick();
        check("bp1_valid", 32'(out_valid), 32'd1);
        check("bp1_a", out_a, 32'd10);
        check("bp1_ready", 32'(in_ready), 32'd1);
        offer(7'b0010011, 3'b100, 1'b0, 5'd1, 5'd0, 32'd20, 32'd0, 32'd2);
        tick();
        check("bp2_held_a", out_a, 32'd10);
        check("bp2_ready", 32'(in_ready), 32'd0);
        offer(7'b0010011, 3'b110, 1'b0, 5'd1, 5'd0, 32'd30, 32'd0, 32'd3);
        tick();
        check("bp3_held_a", out_a, 32'd10);
        check("bp3_held_cntl", 32'(out_cntl), 32'h3);
        check("bp3_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        check("drain2_valid", 32'(out_valid), 32'd1);
        check("drain2_a", out_a, 32'd20);
        check("drain2_cntl", 32'(out_cntl), 32'h2);
        check("drain2_ready", 32'(in_ready), 32'd1);
        tick();
        check("drain3_valid", 32'(out_valid), 32'd1);
        check("drain3_a", out_a, 32'd30);
        check("drain3_cntl", 32'(out_cntl), 32'h1);
        in_valid = 1'b0;
        tick();
        check("drain_empty", 32'(out_valid), 32'd0);

        // Forwarding: EX and WB both target x1
        fwd_ex_valid = 1'b1; fwd_ex_rd = 5'd1; fwd_ex_data = 32'hAA;
        fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd1; fwd_wb_data = 32'hBB;
        offer(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 32'h11, 32'h22, 32'd0);
        tick();
`ifdef ALU_ISSUE_FWD_EN
        check("fwd_ex_a", out_a, 32'hAA);
`else
        check("fwd_ex_a", out_a, 32'h11);
`endif
        check("fwd_ex_b", out_b, 32'h22);
        fwd_ex_valid = 1'b0; fwd_wb_rd = 5'd2;
        offer(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 32'h11, 32'h22, 32'd0);
        tick();
        check("fwd_wb_a", out_a, 32'h11);
`ifdef ALU_ISSUE_FWD_EN
        check("fwd_wb_b", out_b, 32'hBB);
        check("fwd_wb_sd", out_store_data, 32'hBB);
`else
        check("fwd_wb_b", out_b, 32'h22);
        check("fwd_wb_sd", out_store_data, 32'h22);
`endif
        fwd_ex_valid = 1'b1; fwd_ex_rd = 5'd0; fwd_wb_rd = 5'd0;
        offer(7'b0110011, 3'b000, 1'b0, 5'd0, 5'd0, 32'h55, 32'h66, 32'd0);
        tick();
        check("x0_a", out_a, 32'd0);
        check("x0_b", out_b, 32'd0);
        fwd_ex_valid = 1'b0; fwd_wb_valid = 1'b0;

        // Decode table
        vec("sub",    7'b0110011, 3'b000, 1'b1, 4'h4, 1'b1, 32'h100,  32'h200, 1'b0);
        vec("sltu",   7'b0110011, 3'b011, 1'b0, 4'h6, 1'b1, 32'h100,  32'h200, 1'b0);
        vec("sll",    7'b0110011, 3'b001, 1'b0, 4'h7, 1'b1, 32'h100,  32'h200, 1'b0);
        vec("srl",    7'b0110011, 3'b101, 1'b0, 4'h9, 1'b1, 32'h100,  32'h200, 1'b0);
        vec("andi",   7'b0010011, 3'b111, 1'b0, 4'h0, 1'b1, 32'h100,  32'hFFFF_FFF0, 1'b0);
        vec("addi5",  7'b0010011, 3'b000, 1'b1, 4'h3, 1'b1, 32'h100,  32'hFFFF_FFF0, 1'b0);
        vec("slli5",  7'b0010011, 3'b001, 1'b1, 4'hF, 1'b1, 32'h0,    32'h0,   1'b1);
        vec("lui",    7'b0110111, 3'b000, 1'b0, 4'hA, 1'b0, 32'h0,    32'hFFFF_FFF0, 1'b0);
        vec("auipc",  7'b0010111, 3'b000, 1'b0, 4'h3, 1'b1, 32'h1000, 32'hFFFF_FFF0, 1'b0);
        vec("load",   7'b0000011, 3'b010, 1'b0, 4'h3, 1'b1, 32'h100,  32'hFFFF_FFF0, 1'b0);
        vec("store",  7'b0100011, 3'b010, 1'b0, 4'h3, 1'b1, 32'h100,  32'hFFFF_FFF0, 1'b0);
        vec("beq",    7'b1100011, 3'b000, 1'b0, 4'h4, 1'b1, 32'h100,  32'h200, 1'b0);
        vec("bge",    7'b1100011, 3'b101, 1'b0, 4'h5, 1'b1, 32'h100,  32'h200, 1'b0);
        vec("bltu",   7'b1100011, 3'b110, 1'b0, 4'h6, 1'b1, 32'h100,  32'h200, 1'b0);
        vec("br011",  7'b1100011, 3'b011, 1'b0, 4'hF, 1'b1, 32'h0,    32'h0,   1'b1);
        vec("jal",    7'b1101111, 3'b000, 1'b0, 4'h3, 1'b1, 32'h1000, 32'd4,   1'b0);
        vec("jalr",   7'b1100111, 3'b000, 1'b0, 4'h3, 1'b1, 32'h1000, 32'd4,   1'b0);
        vec("badopc", 7'b1111111, 3'b000, 1'b0, 4'hF, 1'b1, 32'h0,    32'h0,   1'b1);
        in_valid = 1'b0;
        tick();

        // Flush with M and S full and a new offer on the same cycle
        out_ready = 1'b0;
        offer(7'b0010011, 3'b000, 1'b0, 5'd1, 5'd0, 32'd10, 32'd0, 32'd1);
        tick();
        offer(7'b0010011, 3'b100, 1'b0, 5'd1, 5'd0, 32'd20, 32'd0, 32'd2);
        tick();
        check("pre_flush_ready", 32'(in_ready), 32'd0);
        offer(7'b0010011, 3'b110, 1'b0, 5'd1, 5'd0, 32'd30, 32'd0, 32'd3);
        flush = 1'b1;
        tick();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("flush_dropped", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-stall
        out_ready = 1'b0;
        offer(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0);
        tick();
        check("stall_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_a", out_a, 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        #2;
        rst_n = 1'b1;
        tick();
        check("post_arst_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
